// File: rtl/delay_sched_pkg.sv
// Shared helpers for the delayed-event scheduler.
package delay_sched_pkg;

  localparam int unsigned MAX_VEC = 64;

  // Index width that never collapses to zero bits (a single entry still needs 1 bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lowest set bit position of vec; returns 0 when vec is all zeros.
  function automatic int unsigned find_first_set(input logic [MAX_VEC-1:0] vec);
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_VEC; i++) begin
      if (!found && vec[i]) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/delay_event_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer advances past the winner.
module rr_arbiter
  import delay_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic [NREQ-1:0]                         i_req,
  input  logic                                    i_enable,
  output logic [NREQ-1:0]                         o_grant,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] o_grant_idx,
  output logic                                    o_grant_valid
);

  localparam int unsigned IW = idx_width(NREQ);

  logic [IW-1:0] r_ptr;

  // Pick the first requester at or after the pointer, wrapping around.
  always_comb begin
    int unsigned w_idx;
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      w_idx = (int'(r_ptr) + off) % NREQ;
      if (!o_grant_valid && i_req[w_idx]) begin
        o_grant_valid   = 1'b1;
        o_grant_idx     = IW'(w_idx);
        o_grant[w_idx]  = 1'b1;
      end
    end
  end

  // Pointer moves only when a grant is actually taken.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_enable && o_grant_valid) begin
      r_ptr <= (o_grant_idx == IW'(NREQ - 1)) ? '0 : o_grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/delay_event_scheduler.sv
// Delayed-event scheduler: requesters post (data, delay); each event is released
// on the shared output port `delay` cycles after acceptance.
module delay_event_scheduler
  import delay_sched_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DW     = 32,
  parameter int unsigned DELAYW = 8,
  parameter int unsigned SLOTS  = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NREQ-1:0]                         req_valid,
  output logic [NREQ-1:0]                         req_ready,
  input  logic [NREQ*DW-1:0]                      req_data,
  input  logic [NREQ*DELAYW-1:0]                  req_delay,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [DW-1:0]                           out_data,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] out_src,
  output logic [$clog2(SLOTS+1)-1:0]              pending
);

  localparam int unsigned IW = idx_width(NREQ);
  localparam int unsigned SW = idx_width(SLOTS);
  localparam int unsigned PW = $clog2(SLOTS + 1);

  typedef struct packed {
    logic              valid;
    logic [DELAYW-1:0] cnt;
    logic [IW-1:0]     src;
    logic [DW-1:0]     data;
  } slot_t;

  slot_t         r_slots [SLOTS];
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic [IW-1:0] r_out_src;

  logic [SLOTS-1:0]   w_free;
  logic [SLOTS-1:0]   w_due;
  logic [MAX_VEC-1:0] w_free_ext;
  logic [MAX_VEC-1:0] w_due_ext;
  logic               w_free_any;
  logic               w_due_any;
  logic [SW-1:0]      w_free_idx;
  logic [SW-1:0]      w_due_idx;
  logic               w_space;
  logic               w_rel_en;
  logic               w_release;
  logic               w_accept;
  logic [NREQ-1:0]    w_grant;
  logic [IW-1:0]      w_grant_idx;
  logic               w_grant_valid;
  logic [DW-1:0]      w_acc_data;
  logic [DELAYW-1:0]  w_acc_delay;
  logic [PW-1:0]      w_pending;

  // Slot status vectors and lowest-index free / due slot selection.
  always_comb begin
    w_free     = '0;
    w_due      = '0;
    w_free_ext = '0;
    w_due_ext  = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      w_free[i] = ~r_slots[i].valid;
      w_due[i]  = r_slots[i].valid && (r_slots[i].cnt == '0);
    end
    w_free_ext[SLOTS-1:0] = w_free;
    w_due_ext[SLOTS-1:0]  = w_due;
    w_free_any = |w_free;
    w_due_any  = |w_due;
    w_free_idx = SW'(find_first_set(w_free_ext));
    w_due_idx  = SW'(find_first_set(w_due_ext));
  end

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req_valid),
    .i_enable     (w_space),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx),
    .o_grant_valid(w_grant_valid)
  );

  assign w_space   = w_free_any && !rst;
  assign req_ready = w_space ? w_grant : '0;
  assign w_accept  = w_grant_valid && w_space;
  assign w_rel_en  = !r_out_valid || out_ready;
  assign w_release = w_rel_en && w_due_any;

  // Data/delay of the granted requester.
  always_comb begin
    w_acc_data  = req_data[w_grant_idx*DW +: DW];
    w_acc_delay = req_delay[w_grant_idx*DELAYW +: DELAYW];
  end

  // Occupied slots plus the output register.
  always_comb begin
    w_pending = PW'(r_out_valid);
    for (int unsigned i = 0; i < SLOTS; i++) begin
      w_pending = w_pending + PW'(r_slots[i].valid);
    end
  end

  // Slot table countdown, accept, release and output register.
  // The accept target is chosen among slots free before the edge, so a slot
  // released at this edge can never be reloaded at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        r_slots[i] <= '0;
      end
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        if (r_slots[i].valid) begin
          if (w_release && (w_due_idx == SW'(i))) begin
            r_slots[i].valid <= 1'b0;
          end else if (r_slots[i].cnt != '0) begin
            r_slots[i].cnt <= r_slots[i].cnt - DELAYW'(1);
          end
        end
      end
      if (w_accept) begin
        r_slots[w_free_idx] <= '{valid: 1'b1, cnt: w_acc_delay, src: w_grant_idx, data: w_acc_data};
      end
      if (w_rel_en) begin
        r_out_valid <= w_due_any;
        if (w_due_any) begin
          r_out_data <= r_slots[w_due_idx].data;
          r_out_src  <= r_slots[w_due_idx].src;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign pending   = w_pending;

endmodule

// File: tb/tb_delay_event_scheduler.sv
// Directed, self-checking bench for delay_event_scheduler (default parameters).
module tb_delay_event_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_data = '0;
  logic [31:0]  req_delay = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_data;
  logic [1:0]   out_src;
  logic [3:0]   pending;

  int n_checks = 0;
  int n_fail   = 0;

  delay_event_scheduler #(
    .NREQ(4), .DW(32), .DELAYW(8), .SLOTS(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_delay(req_delay),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [31:0] d, input logic [7:0] dl);
    req_data[i*32 +: 32] = d;
    req_delay[i*8 +: 8]  = dl;
  endtask

  // Leaves time at posedge+1 with reset released and state cleared.
  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 4'b1111;
    @(posedge clk); #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_delay = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0]  vld;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [1:0]  src;
    logic [31:0] data;
    logic [3:0]  pend;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic        got;
    int          acc;
    int          cons;
    int          sum;
    int          stale;

    // Round-robin table: lanes carry 0xA0+i, delay 0, consumer always ready.
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 32'h0,  4'd0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, 32'h0,  4'd1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd0, 32'hA0, 4'd2};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd1, 32'hA1, 4'd2};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd2, 32'hA2, 4'd2};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 32'hA3, 4'd2};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 32'hA0, 4'd1};
    tbl[7]  = '{4'b0101, 1'b1, 4'b0100, 1'b0, 2'd0, 32'h0,  4'd0};
    tbl[8]  = '{4'b0101, 1'b1, 4'b0001, 1'b0, 2'd0, 32'h0,  4'd1};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 32'hA2, 4'd2};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 32'hA0, 4'd1};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0,  4'd0};

    // Reset state
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_src", 32'(out_src), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);

    // Round-robin table
    for (int i = 0; i < 4; i++) set_lane(i, 32'hA0 + 32'(i), 8'd0);
    for (int r = 0; r < 12; r++) begin
      req_valid = tbl[r].vld;
      out_ready = tbl[r].ordy;
      #1;
      chk($sformatf("rr%0d_ready", r), 32'(req_ready), 32'(tbl[r].rdy));
      chk($sformatf("rr%0d_out_valid", r), 32'(out_valid), 32'(tbl[r].ov));
      chk($sformatf("rr%0d_pending", r), 32'(pending), 32'(tbl[r].pend));
      if (tbl[r].ov) begin
        chk($sformatf("rr%0d_src", r), 32'(out_src), 32'(tbl[r].src));
        chk($sformatf("rr%0d_data", r), out_data, tbl[r].data);
      end
      tick();
    end

    // Single event, delay 10: visible only after E0+11
    do_reset();
    out_ready = 1'b1;
    set_lane(0, 32'hDEADBEEF, 8'd10);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    chk("single_pend0", 32'(pending), 32'h1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("single_ov_e%0d", k), 32'(out_valid), (k == 11) ? 32'h1 : 32'h0);
      chk($sformatf("single_pend_e%0d", k), 32'(pending), (k == 12) ? 32'h0 : 32'h1);
      if (k == 11) begin
        chk("single_data", out_data, 32'hDEADBEEF);
        chk("single_src", 32'(out_src), 32'h0);
      end
    end

    // Contention: delay 3 then delay 2 become due together
    do_reset();
    out_ready = 1'b1;
    set_lane(0, 32'h11, 8'd3);
    set_lane(1, 32'h22, 8'd2);
    req_valid = 4'b0001;
    #1;
    chk("cont_ready0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0010;
    #1;
    chk("cont_ready1", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    for (int k = 2; k <= 6; k++) begin
      tick();
      chk($sformatf("cont_ov_e%0d", k), 32'(out_valid), (k == 4 || k == 5) ? 32'h1 : 32'h0);
      if (k == 4) begin
        chk("cont_src_first", 32'(out_src), 32'h0);
        chk("cont_data_first", out_data, 32'h11);
      end
      if (k == 5) begin
        chk("cont_src_second", 32'(out_src), 32'h1);
        chk("cont_data_second", out_data, 32'h22);
      end
    end

    // Hold: output frozen under back-pressure while the other slot counts down
    do_reset();
    out_ready = 1'b0;
    set_lane(0, 32'h55, 8'd0);
    set_lane(1, 32'h66, 8'd3);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    #1;
    chk("hold_ready1", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("hold_ov%0d", k), 32'(out_valid), 32'h1);
      chk($sformatf("hold_data%0d", k), out_data, 32'h55);
      chk($sformatf("hold_src%0d", k), 32'(out_src), 32'h0);
      chk($sformatf("hold_pend%0d", k), 32'(pending), 32'h2);
      if (k < 5) tick();
    end
    out_ready = 1'b1;
    tick();
    chk("hold_next_ov", 32'(out_valid), 32'h1);
    chk("hold_next_data", out_data, 32'h66);
    chk("hold_next_src", 32'(out_src), 32'h1);
    tick();
    chk("hold_empty_ov", 32'(out_valid), 32'h0);
    chk("hold_empty_pend", 32'(pending), 32'h0);

    // Full and back-pressure: 9 events fit (8 slots + output), then drain
    do_reset();
    out_ready = 1'b0;
    req_delay = '0;
    req_valid = 4'b0001;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      req_data[31:0] = 32'(acc);
      #1;
      got = req_ready[0];
      tick();
      if (got) acc++;
    end
    chk("full_accepts", 32'(acc), 32'd9);
    chk("full_pending", 32'(pending), 32'd9);
    chk("full_ready", 32'(req_ready), 32'h0);
    chk("full_ov", 32'(out_valid), 32'h1);
    chk("full_data", out_data, 32'h0);
    out_ready = 1'b1;
    cons = 0;
    sum  = 0;
    for (int c = 0; c < 30 && (pending != 0 || c < 2); c++) begin
      req_data[31:0] = 32'(acc);
      #1;
      got = req_ready[0];
      if (c == 0) chk("drain_still_full", 32'(got), 32'h0);
      if (c == 1) begin
        chk("drain_resume_ready", 32'(got), 32'h1);
        chk("drain_pend_after_first", 32'(pending), 32'd8);
      end
      if (out_valid) begin
        sum += int'(out_data);
        cons++;
      end
      tick();
      if (got) begin
        acc++;
        req_valid = '0;
      end
    end
    chk("drain_accepts", 32'(acc), 32'd10);
    chk("drain_consumed", 32'(cons), 32'd10);
    chk("drain_sum", 32'(sum), 32'd45);
    chk("drain_pending", 32'(pending), 32'd0);

    // Reset mid-operation with an unconsumed output and two far-off events
    do_reset();
    out_ready = 1'b0;
    set_lane(0, 32'h70, 8'd0);
    set_lane(1, 32'h71, 8'd50);
    set_lane(2, 32'h72, 8'd50);
    req_valid = 4'b0111;
    for (int c = 0; c < 3; c++) tick();
    req_valid = '0;
    chk("mid_pending", 32'(pending), 32'd3);
    chk("mid_ov", 32'(out_valid), 32'h1);
    rst       = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    rst       = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    chk("mid_after_pending", 32'(pending), 32'd0);
    chk("mid_after_ov", 32'(out_valid), 32'h0);
    stale = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (out_valid) stale++;
    end
    chk("mid_no_stale", 32'(stale), 32'd0);
    chk("mid_final_pending", 32'(pending), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_event_scheduler.md
Name: delay_event_scheduler

Overview:
- Synthesizable scheduler for delayed assignments: NREQ requesters post (data, delay) events.
- Each event is released on a single output port `delay` clock cycles after acceptance.
- It is the hardware counterpart of intra-assignment delays (`x = #d v`) used in clocked regions. It shares one slot table and one output channel between all requesters, with round-robin arbitration.

Parameters:
NREQ, 4, number of requesters
DW, 32, event data width
DELAYW, 8, width of per-event delay in cycles
SLOTS, 8, number of pending-event slots (power of two not required)

Ports:
clk  input  1  clock
rst  input  1  reset
req_valid  input  NREQ  per-requester event valid
req_ready  output  NREQ  per-requester accept (at most one bit set)
req_data  input  NREQ*DW  packed event data, requester i at [i*DW +: DW]
req_delay  input  NREQ*DELAYW  packed delay, requester i at [i*DELAYW +: DELAYW]
out_valid  output  1  released event valid
out_ready  input  1  consumer accept
out_data  output  DW  released event data
out_src  output  $clog2(NREQ)  originating requester index
pending  output  $clog2(SLOTS+1)  occupied slots plus output register if valid

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset clears all state:
  - all slots invalid; out_valid=0, out_data=0, out_src=0, pending=0
  - round-robin pointer=0; req_ready=0 during the reset cycle
  - reset mid-operation discards every pending event, including an unconsumed output.
- Accept:
  - each cycle, the arbiter grants at most one requester with req_valid=1, round-robin starting at the pointer.
  - req_ready[g]=1 only if the grant goes to g and at least one slot is free. Free status is judged from pre-edge state.
  - on the accept edge E0: the lowest-index free slot is loaded with {data, src=g, cnt=req_delay}; the pointer moves to (g+1) mod NREQ.
  - pointer is unchanged when nothing is accepted.
  - req_ready is combinational from req_valid and state; requesters must not make req_valid depend on req_ready.
- Countdown:
  - at every edge, each valid slot with cnt>0 decrements by 1.
  - a slot with cnt==0 is "due" and stays due until released; no wrap below 0.
- Release:
  - at an edge where out_valid==0 or out_ready==1, the lowest-index due slot (if any) moves into the output register and is freed at that edge.
  - if no slot is due, out_valid drops to 0 after a consumed output.
  - latency: an event accepted at E0 with delay d, and no back-pressure or contention, gives out_valid=1 after edge E0+d+1. d=0 gives 1-cycle latency.
- Contention and back-pressure:
  - when several slots are due, lower slot index wins; the others wait one release per cycle.
  - while out_valid=1 and out_ready=0, out_data/out_src hold stable; countdowns continue.
- Simultaneous release and accept at the same edge: the freed slot is not reusable until the next cycle.
- Full: all SLOTS occupied → all req_ready=0. The requester keeps req_valid asserted; nothing is dropped.
- pending counts slots after the edge, plus 1 if out_valid. Range 0..SLOTS+1.
- Width rules:
  - cnt is exactly DELAYW bits, so the maximum delay is 2^DELAYW-1.
  - out_src is index-truncated; NREQ=1 uses a width of 1.

Decomposition:
- Package `delay_sched_pkg`: `slot_t` struct {valid, cnt[DELAYW], src, data[DW]} (parameterized via a typedef in the module, or fixed widths with defaults), and a `find_first_set` function.
- Sub-module `rr_arbiter` (NREQ): inputs req, enable; outputs one-hot grant and grant index; holds its own pointer; updates only when enable and a grant occur.

Test Plan:
- Single event:
  - stimulus: reset, then requester 0 posts data=0xDEADBEEF, delay=10, out_ready=1.
  - response: out_valid=1 exactly after edge E0+11 with out_src=0, for one cycle; pending 1→0.
- Round-robin:
  - stimulus: all 4 requesters valid continuously with delay=0.
  - response: accepts go 0,1,2,3,0… one per cycle; outputs appear in the same order at 1-cycle lag.
- Contention:
  - stimulus: requesters 0 and 1 post delays 3 and 2 on consecutive cycles.
  - response: both due on the same cycle; the lower slot (requester 0) releases first, requester 1 the next cycle.
- Full and back-pressure:
  - stimulus: out_ready=0, post 9 events.
  - response: 8 accepted into slots, 1 into output; pending=9; req_ready=0 thereafter.
  - then raise out_ready: one release per cycle and a new accept resumes the cycle after the first free.
- Hold:
  - stimulus: out_ready=0 with out_valid=1 for 5 cycles.
  - response: out_data/out_src unchanged; remaining slots still count down.
- Reset mid-operation:
  - stimulus: assert rst with 3 pending events.
  - response: next cycle pending=0, out_valid=0; no stale release after deassert.
